// File: rtl/fft8_pkg.sv
// Shared definitions for the 8-point radix-2 DIT FFT sequencer and its address generator.
package fft8_pkg;

    localparam int N              = 8;
    localparam int LOG2N          = 3;
    localparam int BFLY_PER_STAGE = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [LOG2N-1:0] addr_a;
        logic [LOG2N-1:0] addr_b;
        logic [1:0]       tw_idx;
        logic             tw_conj;
    } bf_cmd_t;

endpackage

// File: rtl/fft8_addr_gen.sv
// Combinational map from (stage, butterfly index k) to in-place addresses and twiddle index.
module fft8_addr_gen
    import fft8_pkg::*;
(
    input  logic [1:0]       stage,
    input  logic [1:0]       k,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [1:0]       tw_idx
);

    // span = 1<<s, j = k & (span-1), grp = k>>s; each case is that formula unrolled.
    always_comb begin
        addr_a = '0;
        addr_b = '0;
        tw_idx = '0;
        case (stage)
            2'd0: begin
                addr_a = {k, 1'b0};
                addr_b = addr_a + 3'd1;
                tw_idx = 2'd0;
            end
            2'd1: begin
                addr_a = {k[1], 1'b0, k[0]};
                addr_b = addr_a + 3'd2;
                tw_idx = {k[0], 1'b0};
            end
            2'd2: begin
                addr_a = {1'b0, k};
                addr_b = addr_a + 3'd4;
                tw_idx = k;
            end
            default: begin
                addr_a = '0;
                addr_b = '0;
                tw_idx = '0;
            end
        endcase
    end

endmodule

// File: rtl/fft8_sched.sv
// Butterfly command sequencer for the 8-point FFT: 3 stages x 4 butterflies with writeback tracking.
// Optional inverse-transform twiddle conjugation is enabled by defining FFT8_SCHED_IFFT_EN.
module fft8_sched
    import fft8_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       inverse,
    output logic       busy,
    output logic       done,
    output logic       bf_valid,
    input  logic       bf_ready,
    output logic [2:0] bf_addr_a,
    output logic [2:0] bf_addr_b,
    output logic [1:0] tw_idx,
    output logic       tw_conj,
    output logic [1:0] stage,
    input  logic       wb_valid
);

    state_t     state, state_nx;
    logic [1:0] stage_q;
    logic [1:0] k_q;
    logic [2:0] outst_q;
    logic [2:0] wbcnt_q;
    logic       hs;
    logic       wb_ok;
    logic       drain_met;
    bf_cmd_t    cmd;

    // Writebacks with nothing outstanding are dropped so the counters saturate at zero.
    assign hs        = bf_valid && bf_ready;
    assign wb_ok     = wb_valid && (state != IDLE) && (outst_q != 3'd0);
    assign drain_met = ({1'b0, wbcnt_q} + {3'b000, wb_ok}) >= 4'(BFLY_PER_STAGE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ISSUE;
            ISSUE:   if (hs && k_q == 2'd3) state_nx = DRAIN;
            DRAIN:   if (drain_met) state_nx = (stage_q == 2'd2) ? DONE : ISSUE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= 2'd0;
            k_q     <= 2'd0;
            outst_q <= 3'd0;
            wbcnt_q <= 3'd0;
        end else begin
            outst_q <= outst_q + {2'b00, hs} - {2'b00, wb_ok};
            case (state)
                IDLE: if (start) begin
                    stage_q <= 2'd0;
                    k_q     <= 2'd0;
                    wbcnt_q <= 3'd0;
                end
                ISSUE: begin
                    if (hs)    k_q     <= k_q + 2'd1;
                    if (wb_ok) wbcnt_q <= wbcnt_q + 3'd1;
                end
                // The last writeback of a stage may advance the stage in the same cycle it arrives.
                DRAIN: begin
                    if (drain_met) begin
                        wbcnt_q <= 3'd0;
                        if (stage_q != 2'd2) stage_q <= stage_q + 2'd1;
                    end else if (wb_ok) begin
                        wbcnt_q <= wbcnt_q + 3'd1;
                    end
                end
                DONE: begin
                    stage_q <= 2'd0;
                    wbcnt_q <= 3'd0;
                end
                default: ;
            endcase
        end
    end

    fft8_addr_gen u_addr_gen (
        .stage  (stage_q),
        .k      (k_q),
        .addr_a (cmd.addr_a),
        .addr_b (cmd.addr_b),
        .tw_idx (cmd.tw_idx)
    );

`ifdef FFT8_SCHED_IFFT_EN
    logic inv_q;

    always_ff @(posedge clk) begin
        if (rst)                        inv_q <= 1'b0;
        else if (state == IDLE && start) inv_q <= inverse;
    end

    assign cmd.tw_conj = inv_q && busy;
`else
    logic unused_inverse;

    assign unused_inverse = inverse;
    assign cmd.tw_conj    = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign bf_valid  = (state == ISSUE) && (outst_q < 3'(MAX_OUTSTANDING));
    assign bf_addr_a = bf_valid ? cmd.addr_a : 3'd0;
    assign bf_addr_b = bf_valid ? cmd.addr_b : 3'd0;
    assign tw_idx    = bf_valid ? cmd.tw_idx : 2'd0;
    assign tw_conj   = cmd.tw_conj;
    assign stage     = stage_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && state != IDLE && wb_valid)
            assert (outst_q != 3'd0)
            else $error("fft8_sched: wb_valid with no butterfly outstanding");
    end
`endif

endmodule

// File: tb/tb_fft8_sched.sv
// Directed scoreboard bench for fft8_sched; FFT8_SCHED_IFFT_EN selects the expected tw_conj behaviour.
module tb_fft8_sched;

    logic       clk = 1'b0;
    logic       rst, start_s, inverse, bf_ready, wb_s, sel;
    logic       start0, start1, wb0, wb1;
    logic       busy0, done0, bv0, conj0, busy1, done1, bv1, conj1;
    logic [2:0] a0, b0, a1, b1;
    logic [1:0] tw0, st0, tw1, st1;
    logic       busy_o, done_o, bv_o, conj_o;
    logic [2:0] a_o, b_o;
    logic [1:0] tw_o, st_o;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic [1:0] tw;
        logic       cj;
        logic [1:0] st;
    } cmd_t;

    cmd_t exp_q[$];

    always #5 clk = ~clk;

    fft8_sched #(.MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst(rst), .start(start0), .inverse(inverse), .busy(busy0), .done(done0),
        .bf_valid(bv0), .bf_ready(bf_ready), .bf_addr_a(a0), .bf_addr_b(b0), .tw_idx(tw0),
        .tw_conj(conj0), .stage(st0), .wb_valid(wb0)
    );

    fft8_sched #(.MAX_OUTSTANDING(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .inverse(inverse), .busy(busy1), .done(done1),
        .bf_valid(bv1), .bf_ready(bf_ready), .bf_addr_a(a1), .bf_addr_b(b1), .tw_idx(tw1),
        .tw_conj(conj1), .stage(st1), .wb_valid(wb1)
    );

    // Only the selected instance sees start/writebacks; the other stays idle.
    assign start0 = sel ? 1'b0 : start_s;
    assign start1 = sel ? start_s : 1'b0;
    assign wb0    = sel ? 1'b0 : wb_s;
    assign wb1    = sel ? wb_s : 1'b0;
    assign busy_o = sel ? busy1 : busy0;
    assign done_o = sel ? done1 : done0;
    assign bv_o   = sel ? bv1 : bv0;
    assign conj_o = sel ? conj1 : conj0;
    assign a_o    = sel ? a1 : a0;
    assign b_o    = sel ? b1 : b0;
    assign tw_o   = sel ? tw1 : tw0;
    assign st_o   = sel ? st1 : st0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic cmd_t mk(input int s, input int k, input bit cj);
        cmd_t c;
        int span, j, grp, a;
        span = 1 << s;
        j    = k & (span - 1);
        grp  = k >> s;
        a    = grp * 2 * span + j;
        c.a  = 3'(a);
        c.b  = 3'(a + span);
        c.tw = 2'(j << (2 - s));
        c.cj = cj;
        c.st = 2'(s);
        return c;
    endfunction

    task automatic chk_reset();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_valid", bv_o, 0);
        chk("rst_addr_a", a_o, 0);
        chk("rst_addr_b", b_o, 0);
        chk("rst_tw_idx", tw_o, 0);
        chk("rst_tw_conj", conj_o, 0);
        chk("rst_stage", st_o, 0);
    endtask

    // One transform: start in cycle 0, writebacks lat cycles after each handshake.
    task automatic run(input int lat, input int mode, input bit inv, input bit chk_t,
                       input bit abort_s1, input int extra_start, input int mx);
        int   cyc, hs_n, wb_tot, out_m;
        int   wbq[$];
        bit   fin, aborted, hs, wbv, cj;
        cmd_t f;
        cyc = 0; hs_n = 0; wb_tot = 0; out_m = 0;
        fin = 0; aborted = 0;
`ifdef FFT8_SCHED_IFFT_EN
        cj = inv;
`else
        cj = 1'b0;
`endif
        exp_q.delete();
        while (!fin && cyc < 400) begin
            @(negedge clk);
            if (abort_s1 && st_o == 2'd1) begin
                aborted = 1;
                break;
            end
            if (chk_t) chk("busy_window", busy_o, (cyc >= 1 && cyc <= 19));
            if (cyc == 0) begin
                start_s = 1'b1;
                inverse = inv;
                for (int s = 0; s < 3; s++)
                    for (int k = 0; k < 4; k++) exp_q.push_back(mk(s, k, cj));
            end else begin
                start_s = (cyc == extra_start);
            end
            bf_ready = (mode == 0) ? 1'b1 : cyc[0];
            wbv = (wbq.size() > 0 && wbq[0] == cyc);
            if (wbv) void'(wbq.pop_front());
            wb_s = wbv;
            if (out_m >= mx) chk("outstanding_limit", bv_o, 0);
            hs = bv_o && bf_ready;
            if (bv_o) begin
                chk("cmd_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    f = exp_q[0];
                    chk("addr_a", a_o, f.a);
                    chk("addr_b", b_o, f.b);
                    chk("tw_idx", tw_o, f.tw);
                    chk("tw_conj", conj_o, f.cj);
                    chk("stage", st_o, f.st);
                    if (hs) begin
                        chk("wb_before_next_stage", wb_tot >= 4 * int'(f.st), 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (hs) begin
                wbq.push_back(cyc + lat);
                hs_n++;
            end
            if (wbv) wb_tot++;
            out_m = out_m + int'(hs) - int'(wbv);
            if (done_o) begin
                if (chk_t) chk("done_cycle", cyc, 19);
                fin = 1;
            end
            cyc++;
        end
        if (!aborted) begin
            chk("finished_in_budget", fin, 1);
            chk("cmd_count", hs_n, 12);
            chk("scoreboard_empty", exp_q.size(), 0);
            chk("writeback_count", wb_tot, 12);
            @(negedge clk);
            start_s = 1'b0;
            wb_s    = 1'b0;
            chk("done_one_cycle", done_o, 0);
            chk("busy_after_done", busy_o, 0);
        end else begin
            chk("abort_reached_stage1", st_o, 1);
        end
    endtask

    initial begin
        rst = 1'b1; start_s = 1'b0; inverse = 1'b0; bf_ready = 1'b0; wb_s = 1'b0; sel = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        run(2, 0, 1'b1, 1'b1, 1'b0, -1, 4);

        @(negedge clk) wb_s = 1'b1;
        @(negedge clk) wb_s = 1'b0;
        run(2, 1, 1'b0, 1'b0, 1'b0, -1, 4);

        run(3, 0, 1'b0, 1'b0, 1'b0, -1, 4);

        run(2, 0, 1'b1, 1'b0, 1'b1, -1, 4);
        rst = 1'b1; start_s = 1'b0; wb_s = 1'b0; bf_ready = 1'b0;
        @(negedge clk);
        chk_reset();
        rst = 1'b0;
        run(2, 0, 1'b0, 1'b0, 1'b0, 3, 4);

        sel = 1'b1;
        @(negedge clk);
        run(2, 0, 1'b0, 1'b0, 1'b0, -1, 1);
        sel = 1'b0;

        run(1, 0, 1'b1, 1'b0, 1'b0, -1, 4);
        run(1, 0, 1'b0, 1'b0, 1'b0, -1, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft8_sched.md
Name: fft8_sched

Overview:
- Sequencing controller for the 8-point radix-2 DIT FFT datapath.
- On `start`, issues the 12 butterfly operations (3 stages × 4 butterflies) to the shared butterfly unit in order.
- Each operation carries two in-place sample-memory addresses and the 2-bit twiddle index that drives the 8-point twiddle LUT.
- Tracks writebacks so a stage never reads data the previous stage has not yet written. Input data is already in bit-reversed order; output is in natural order.

Parameters:
- MAX_OUTSTANDING, 4, maximum butterflies issued but not yet written back (1..4); `bf_valid` is held low while at the limit.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle request to begin a transform; accepted only in IDLE
- inverse  input  1  transform direction, sampled with an accepted `start` (used only with the optional feature)
- busy  output  1  high from accepted `start` until `done`
- done  output  1  one-cycle pulse when the last stage-2 writeback has been received
- bf_valid  output  1  butterfly command valid
- bf_ready  input  1  butterfly unit accepts the command when `bf_valid && bf_ready`
- bf_addr_a  output  3  upper-leg sample address
- bf_addr_b  output  3  lower-leg sample address
- tw_idx  output  2  twiddle LUT index (0..3)
- tw_conj  output  1  conjugate twiddle (inverse transform)
- stage  output  2  current stage 0..2
- wb_valid  input  1  one pulse per completed butterfly writeback

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. `rst` overrides everything, including mid-transform.
- Reset values: state=IDLE; busy=0; done=0; bf_valid=0; bf_addr_a=0; bf_addr_b=0; tw_idx=0; tw_conj=0; stage=0; all counters 0.
- States:
  - IDLE: on `start`, go to ISSUE with stage=0, k=0, busy=1. `start` while busy is ignored.
  - ISSUE: `bf_valid`=1 when outstanding < MAX_OUTSTANDING. Each handshake increments k. After the handshake with k=3, go to DRAIN.
  - DRAIN: `bf_valid`=0; wait until the stage writeback count reaches 4. Then, if stage<2, stage++, k=0, back to ISSUE; if stage=2, go to DONE.
  - DONE: `done`=1 for one cycle, `busy`=0 next cycle, back to IDLE. `start` in this cycle is ignored.
- Address and twiddle generation (combinational from stage s and k, outputs stable while `bf_valid && !bf_ready`):
  - span = 1<<s; j = k & (span-1); grp = k>>s
  - bf_addr_a = grp·2·span + j; bf_addr_b = bf_addr_a + span
  - tw_idx = j << (2-s)
  - Resulting sequence:
    - s0: (0,1,0)(2,3,0)(4,5,0)(6,7,0)
    - s1: (0,2,0)(1,3,2)(4,6,0)(5,7,2)
    - s2: (0,4,0)(1,5,1)(2,6,2)(3,7,3)
- Outstanding counter (3 bits): +1 on handshake, −1 on `wb_valid`, net 0 when both occur in the same cycle.
- Stage writeback counter (3 bits): counts `wb_valid` and clears on stage advance.
- `wb_valid` arriving in IDLE is ignored, no counter change.
- `wb_valid` with outstanding=0 is a protocol error: counters saturate at 0; assertion in simulation.
- No stage-(s+1) command issues before all 4 stage-s writebacks have been received, even when `wb_valid` arrives in the same cycle as the last handshake.
- Minimum transform time with `bf_ready`=1 and writeback latency L: 3·(4+L)+1 cycles.

Optional Feature:
- FFT8_SCHED_IFFT_EN
  - Defined: `inverse` is latched on accepted `start`; `tw_conj` equals the latched value while busy; the latch clears on reset.
  - Undefined: `inverse` is ignored and `tw_conj` is tied to 0.

Decomposition:
- Shared package `fft8_pkg`:
  - constants N=8, LOG2N=3, BFLY_PER_STAGE=4
  - state enum {IDLE, ISSUE, DRAIN, DONE}
  - command record typedef {addr_a, addr_b, tw_idx, tw_conj}
- One sub-module, `fft8_addr_gen`: purely combinational, maps (stage, k) to (addr_a, addr_b, tw_idx), reusable by the verification model.

Test Plan:
- Happy path: `bf_ready`=1, writeback latency 2, `start` at cycle 0 → exactly the 12 commands listed above, in order; `done` at cycle 19; `busy` high for cycles 1..19.
- Backpressure: `bf_ready` toggles 0/1 every cycle → each command held stable while `bf_ready`=0; same 12-command order; no dropped or duplicated commands.
- Same-cycle events: `wb_valid` coincident with the 4th stage-0 handshake → outstanding count stays correct; stage-1 first command (0,2,0) issues only after the 4th writeback.
- Outstanding limit: MAX_OUTSTANDING=1 → `bf_valid` low between each handshake and its `wb_valid`; 12 alternating issue/writeback pairs.
- Reset mid-operation: `rst` during stage 1 → next cycle all outputs at reset values; a new `start` restarts at stage 0 with command (0,1,0); an extra `start` while busy has no effect.
- With FFT8_SCHED_IFFT_EN, `start` with inverse=1 → `tw_conj`=1 on all 12 commands; the following run with inverse=0 → `tw_conj`=0.
